// File: rtl/hex_display_scanner_pkg.sv
// Shared constants, FSM states and sizing helper for the hex display scanner.
package hex_display_scanner_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_GAP,
        ST_ON
    } state_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/hex_display_scanner_hexdigit.sv
// Hex nibble to active-low gfedcba segment pattern.
module hex_display_scanner_hexdigit (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        unique case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b0100111;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed seven-segment scanner with frame-aligned loads.
// Optional LEADING_ZERO_SUPPRESS_EN blanks leading zero digits.
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_start
);

    localparam int CW = cnt_width(REFRESH_DIV, GAP_CYCLES);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    state_t                     state;
    logic [IW-1:0]              idx;
    logic [CW-1:0]              cnt;
    logic                       first;
    logic [NUM_DIGITS-1:0][3:0] disp;
    logic [NUM_DIGITS-1:0][3:0] pend_data;
    logic                       pend;
    logic [3:0]                 nib;
    logic [6:0]                 seg_dec;
    logic [NUM_DIGITS-1:0]      sel_n;
    logic [NUM_DIGITS-1:0]      dark;
    logic                       gap_done;
    logic                       boundary;
    logic                       xfer;

    assign gap_done   = (state == ST_GAP) && (cnt == GAP_LAST);
    assign boundary   = gap_done && !first && (idx == IDX_LAST);
    assign xfer       = load_valid && load_ready;
    assign load_ready = ~pend;
    assign nib        = disp[idx];

    hex_display_scanner_hexdigit u_hexdigit (
        .nibble (nib),
        .seg    (seg_dec)
    );

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_n[i] = (idx != IW'(i));
        end
    end

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic zero_above;

    // Digit 0 is excluded so an all-zero value still shows "0".
    always_comb begin
        dark       = blank_mask;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (disp[i] == 4'h0);
            dark[i]    = dark[i] | zero_above;
        end
    end
`else
    always_comb begin
        dark = blank_mask;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_GAP;
            idx         <= '0;
            cnt         <= '0;
            first       <= 1'b1;
            seg_out     <= SEG_BLANK;
            digit_sel_n <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            unique case (state)
                ST_GAP: begin
                    seg_out     <= SEG_BLANK;
                    digit_sel_n <= '1;
                    if (gap_done) begin
                        cnt   <= '0;
                        state <= ST_ON;
                        first <= 1'b0;
                        // The gap after reset leads straight into digit 0.
                        if (!first) begin
                            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ON: begin
                    seg_out     <= dark[idx] ? SEG_BLANK : seg_dec;
                    digit_sel_n <= sel_n;
                    frame_start <= (idx == '0) && (cnt == '0);
                    if (cnt == ON_LAST) begin
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp      <= '0;
            pend_data <= '0;
            pend      <= 1'b0;
        end else if (boundary && pend) begin
            disp <= pend_data;
            pend <= 1'b0;
        end else if (xfer) begin
            pend_data <= load_data;
            pend      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner against a time-based model.
module tb_hex_display_scanner;

    localparam int N = 4;
    localparam int R = 4;
    localparam int G = 2;
    localparam int P = G + R;
    localparam int F = N * P;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic [3:0]  blank_mask = '0;
    logic [6:0]  seg_out;
    logic [3:0]  digit_sel_n;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    int          cyc;
    logic [15:0] m_disp;
    logic [15:0] m_pdata;
    bit          m_pend;

    string lit [16] = '{
        "abcdef", "bc", "abdeg", "abcdg",
        "bcfg", "acdfg", "acdefg", "abc",
        "abcdefg", "abcfg", "abcefg", "cdefg",
        "deg", "bcdeg", "adefg", "aefg"
    };

    hex_display_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .GAP_CYCLES  (G)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .blank_mask  (blank_mask),
        .seg_out     (seg_out),
        .digit_sel_n (digit_sel_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        string      s;
        logic [6:0] g;
        g = 7'h7F;
        s = lit[v];
        for (int i = 0; i < s.len(); i++) begin
            g[int'(s[i]) - 97] = 1'b0;
        end
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        m_disp  = '0;
        m_pdata = '0;
        m_pend  = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seg"}, 32'(seg_out), 32'h7F);
        chk({tag, "_sel"}, 32'(digit_sel_n), 32'hF);
        chk({tag, "_fs"}, 32'(frame_start), 32'h0);
        chk({tag, "_rdy"}, 32'(load_ready), 32'h1);
    endtask

    task automatic step(input bit v, input logic [15:0] d,
                        input logic [3:0] mask);
        int         ph;
        int         dg;
        bit         dark;
        logic [6:0] es;
        logic [3:0] esel;
        bit         efs;
        load_valid = v;
        load_data  = d;
        blank_mask = mask;
        ph   = cyc % P;
        dg   = (cyc / P) % N;
        es   = 7'h7F;
        esel = 4'hF;
        efs  = 1'b0;
        if (ph >= G) begin
            esel = ~(4'b0001 << dg);
            efs  = (ph == G) && (dg == 0);
            dark = mask[dg];
`ifdef LEADING_ZERO_SUPPRESS_EN
            if (dg != 0 && (m_disp >> (4 * dg)) == 16'h0) dark = 1'b1;
`endif
            if (!dark) es = glyph(4'(m_disp >> (4 * dg)));
        end
        if (((cyc + 1) % F == G) && (cyc + 1 > G) && m_pend) begin
            m_disp = m_pdata;
            m_pend = 1'b0;
        end else if (v && !m_pend) begin
            m_pdata = d;
            m_pend  = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("seg", 32'(seg_out), 32'(es));
        chk("sel", 32'(digit_sel_n), 32'(esel));
        chk("fs", 32'(frame_start), 32'(efs));
        chk("rdy", 32'(load_ready), 32'(!m_pend));
        cyc++;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset_n = 1'b1;

        repeat (30) step(1'b0, 16'h0, 4'h0);

        step(1'b1, 16'h1A3F, 4'h0);
        while (m_pend) step(1'b1, 16'hFFFF, 4'h0);
        repeat (2 * F) step(1'b0, 16'h0, 4'h0);

        while (!(((cyc / P) % N == 2) && (cyc % P == G + 1)))
            step(1'b0, 16'h0, 4'h0);
        repeat (3) step(1'b0, 16'h0, 4'b0100);
        repeat (4) step(1'b0, 16'h0, 4'h0);

        repeat (300) begin
            step($urandom_range(0, 3) == 0, 16'($urandom),
                 ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
        end

        while (m_pend) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h0050, 4'h0);
        repeat (2 * F) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h0000, 4'h0);
        repeat (2 * F) step(1'b0, 16'h0, 4'h0);

        while (cyc % F != P + G) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h9876, 4'h0);
        step(1'b0, 16'h0, 4'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        repeat (2 * F) step(1'b0, 16'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Time-multiplexed driver for a common-anode seven-segment bank. It shares one hexdigit decoder across NUM_DIGITS digits.
- Cycles a digit-select, with an all-off anti-ghost gap between digits.
- Accepts new display values over a valid/ready handshake.
- Applies new values only at frame boundaries, so no partial frame is ever displayed.
Sits between the register/status logic and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8)
REFRESH_DIV, 50000, clock cycles each digit is lit (legal >= 2)
GAP_CYCLES, 500, clock cycles all digits are off between digits (legal >= 1)

Ports:
clk  input  1  system clock, single clock domain
reset_n  input  1  asynchronous active-low reset
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  block can accept a load
load_data  input  4*NUM_DIGITS  nibble i -> digit i (digit 0 = bits [3:0], rightmost)
blank_mask  input  NUM_DIGITS  bit i = 1 keeps digit i dark; live input
seg_out  output  7  segments gfedcba, active-low, registered
digit_sel_n  output  NUM_DIGITS  anode enables, active-low, one-cold or all-high, registered
frame_start  output  1  one-cycle pulse when digit 0 begins its ON phase

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: seg_out=7'h7F, digit_sel_n all 1, frame_start=0, load_ready=1.
- Reset values (internal): state=GAP, idx=0, cnt=0, display reg=0, pending=0.
- Counter width is $clog2 of max(REFRESH_DIV, GAP_CYCLES). idx width is $clog2(NUM_DIGITS), minimum 1.
- FSM states: GAP and ON.
- GAP: all digits off and seg_out=7'h7F.
  - Count GAP_CYCLES cycles.
  - On the last count: advance idx. Wrap from NUM_DIGITS-1 to 0 is the frame boundary.
  - If leaving GAP with the reset idx=0, the first ON is digit 0 with no advance.
  - Go to ON with cnt=0.
- ON: digit_sel_n[idx]=0, others 1.
  - seg_out = decode(display nibble idx), or 7'h7F if blank_mask[idx].
  - blank_mask is sampled each cycle.
  - Count REFRESH_DIV cycles, then go to GAP.
- Output latency: seg_out/digit_sel_n update one cycle after the state/idx change. Segments and anode always change in the same cycle.
- Decode table, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - c=0100111, d=0100001, E=0000110, F=0001110
- frame_start: pulses in the same cycle digit_sel_n[0] first goes low in each frame. The first pulse after reset comes at the end of the initial GAP.
- Load handshake: a transfer occurs when load_valid && load_ready.
  - On transfer: capture load_data into the pending buffer; pending=1; load_ready=0 next cycle.
  - At the frame boundary with pending=1: copy pending into the display reg; pending=0; load_ready=1 next cycle.
  - The new value is first shown on digit 0 of that frame.
- Simultaneous transfer and frame boundary (possible only if pending was 0): data goes to pending and is applied at the next boundary.
- load_valid while load_ready=0 is ignored. Upstream holds data until ready, per handshake.
- Frame period = NUM_DIGITS*(REFRESH_DIV+GAP_CYCLES) cycles.
- Reset mid-operation: all outputs return to reset values immediately (async). A pending load is discarded.

Optional Feature:
LEADING_ZERO_SUPPRESS_EN:
- Defined: a digit displays blank (7'h7F) if its nibble and all higher-index nibbles of the display reg are 0.
- Digit 0 is never suppressed, so 0x0000 shows "0".
- Suppression ORs with blank_mask.
- Undefined: all digits show their nibble, subject only to blank_mask.

Decomposition:
- Shared package: segment constant SEG_BLANK=7'h7F; FSM state enum (ST_GAP, ST_ON); helper function for counter width.
- Decode table stays in the existing hexdigit decoder, instantiated once as the shared resource. Its input is muxed from the display reg by idx.
- No further sub-module.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=2 (24-cycle frame).
1. Reset release, display 0 -> 2 gap cycles, then digit_sel_n=1110, seg_out=1000000, frame_start=1 for 1 cycle. Digits then cycle 1101, 1011, 0111 with 2 all-high cycles between each.
2. Load 16'h1A3F mid-frame -> load_ready low next cycle; segments unchanged until the boundary.
   - At the boundary: digit0=0001110 (F), digit1=0110000 (3), digit2=0001000 (A), digit3=1111001 (1).
   - load_ready high one cycle after the boundary.
3. Second load_valid while load_ready=0 with 16'hFFFF -> ignored; display stays 16'h1A3F for following frames.
4. blank_mask=4'b0100 asserted during digit 2 ON -> seg_out=7'h7F from the next cycle; digit_sel_n still 1011.
5. Assert reset_n=0 mid-ON with a pending load -> outputs at reset values asynchronously. After release, display=0 and load_ready=1.
6. With LEADING_ZERO_SUPPRESS_EN, load 16'h0050 -> digits 3 and 2 blank, digit 1=0010010 (5), digit 0=1000000 (0). Load 16'h0000 -> only digit 0 lit, showing "0".
